// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state type,
// legal operand widths and the bit-counter width helper.
package serial_arith_pkg;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // A 1-bit operand still needs a 1-bit counter, so clamp at one.
    function automatic int cnt_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder from two half adders and an OR, the mirror image of
// full_subtractor's borrow structure.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    logic ha0_sum;
    logic ha0_carry;
    logic ha1_carry;

    half_adder u_ha0 (
        .a         (a),
        .b         (b),
        .sum       (ha0_sum),
        .carry_out (ha0_carry)
    );

    half_adder u_ha1 (
        .a         (ha0_sum),
        .b         (carry_in),
        .sum       (sum),
        .carry_out (ha1_carry)
    );

    assign carry_out = ha0_carry | ha1_carry;

endmodule

// File: rtl/half_adder.sv
// One-bit half adder used as the building block of full_adder.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry_out
);

    assign sum       = a ^ b;
    assign carry_out = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full_adder, a carry flip-flop and a
// three-state FSM; {carry_out, sum} = a + b + carry_in after WIDTH shift edges.
module serial_adder
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   work_reg;
    logic [WIDTH-1:0]   work_next;
    logic [WIDTH-1:0]   sum_reg;
    logic               carry_reg;
    logic               carry_out_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               fa_sum;
    logic               fa_carry;

    full_adder u_fa (
        .a         (a_reg[0]),
        .b         (b_reg[0]),
        .carry_in  (carry_reg),
        .sum       (fa_sum),
        .carry_out (fa_carry)
    );

    // New sum bit enters at the MSB so the LSB-first result ends up aligned.
    generate
        if (WIDTH == 1) begin : g_work_w1
            assign work_next = fa_sum;
        end else begin : g_work_wn
            assign work_next = {fa_sum, work_reg[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            work_reg      <= '0;
            sum_reg       <= '0;
            carry_reg     <= 1'b0;
            carry_out_reg <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= carry_in;
                        cnt_reg   <= '0;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_reg     <= a_reg >> 1;
                    b_reg     <= b_reg >> 1;
                    work_reg  <= work_next;
                    carry_reg <= fa_carry;
                    cnt_reg   <= cnt_reg + CNT_W'(1);
                    // Results are published only on the final bit, so sum
                    // stays stable throughout the shifting.
                    if (cnt_reg == CNT_LAST) begin
                        sum_reg       <= work_next;
                        carry_out_reg <= fa_carry;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign ready     = (state_reg == IDLE);
    assign done      = (state_reg == DONE);
    assign sum       = sum_reg;
    assign carry_out = carry_out_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8 and WIDTH=1 with a result scoreboard.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cin8 = 1'b0;
    logic       ready8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       cin1 = 1'b0;
    logic       ready1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [8:0] q8[$];
    logic [1:0] q1[$];

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .carry_in(cin8),
        .ready(ready8), .done(done8), .sum(sum8), .carry_out(cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .carry_in(cin1),
        .ready(ready1), .done(done1), .sum(sum1), .carry_out(cout1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin : mon8
        logic [8:0] e;
        if (!rst && done8) begin
            if (q8.size() == 0) begin
                chk("unexpected_done8", 1, 0);
            end else begin
                e = q8.pop_front();
                chk("result8", {cout8, sum8}, e);
                $display("W8 result a+b+cin: got %0h expected %0h", {cout8, sum8}, e);
            end
        end
    end

    always @(negedge clk) begin : mon1
        logic [1:0] e;
        if (!rst && done1) begin
            if (q1.size() == 0) begin
                chk("unexpected_done1", 1, 0);
            end else begin
                e = q1.pop_front();
                chk("result1", {cout1, sum1}, e);
                $display("W1 result a+b+cin: got %0h expected %0h", {cout1, sum1}, e);
            end
        end
    end

    task automatic run_op8(input logic [7:0] av, input logic [7:0] bv, input logic c,
                           input logic pulse_mid);
        logic [8:0] prev;
        @(negedge clk);
        a8 = av; b8 = bv; cin8 = c; start8 = 1'b1;
        q8.push_back({1'b0, av} + {1'b0, bv} + {8'd0, c});
        prev = {cout8, sum8};
        @(negedge clk);                         // after E0
        start8 = 1'b0;
        chk("busy_e0", {ready8, done8}, 2'b00);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);                     // after E_k
            if (pulse_mid && k >= 2 && k <= 4) begin
                start8 = 1'b1;
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end else begin
                start8 = 1'b0;
            end
            chk("busy_shift", {ready8, done8}, 2'b00);
            chk("hold_shift", {cout8, sum8}, prev);
        end
        @(negedge clk);                         // after E8
        start8 = 1'b0;
        chk("done_e8", {ready8, done8}, 2'b01);
        @(negedge clk);                         // after E9
        chk("idle_e9", {ready8, done8}, 2'b10);
    endtask

    initial begin
        logic [7:0] ba[3];
        logic [7:0] bb[3];
        logic       bc[3];
        logic [8:0] be[3];
        int last_done;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset8", {ready8, done8, cout8, sum8}, {2'b10, 1'b0, 8'h00});
        chk("reset1", {ready1, done1, cout1, sum1}, {2'b10, 1'b0, 1'b0});
        rst = 1'b0;

        run_op8(8'h5A, 8'h3C, 1'b0, 1'b0);
        chk("sum_5a_3c", {cout8, sum8}, 9'h096);
        run_op8(8'hFF, 8'h01, 1'b0, 1'b0);
        run_op8(8'hFF, 8'hFF, 1'b1, 1'b1);
        chk("sum_ff_ff_1", {cout8, sum8}, 9'h1FF);

        // Asynchronous reset after four shift edges aborts the operation.
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("async_reset", {ready8, done8, cout8, sum8}, {2'b10, 1'b0, 8'h00});
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("no_done_after_abort", {ready8, done8}, 2'b10);
        run_op8(8'h01, 8'h02, 1'b0, 1'b0);
        chk("sum_01_02", {cout8, sum8}, 9'h003);

        // start held high: back-to-back operations every WIDTH+2 edges.
        ba[0] = 8'h12; bb[0] = 8'h34; bc[0] = 1'b0;
        ba[1] = 8'h80; bb[1] = 8'h80; bc[1] = 1'b1;
        ba[2] = 8'hF0; bb[2] = 8'h0F; bc[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            be[i] = {1'b0, ba[i]} + {1'b0, bb[i]} + {8'd0, bc[i]};
            q8.push_back(be[i]);
        end
        @(negedge clk);
        a8 = ba[0]; b8 = bb[0]; cin8 = bc[0]; start8 = 1'b1;
        last_done = 0;
        for (int k = 0; k < 3; k++) begin
            for (int t = 0; t < 20 && !done8; t++) @(negedge clk);
            if (!done8) begin
                chk("b2b_timeout", 0, 1);
            end else begin
                if (k > 0) chk("b2b_spacing", 64'(cyc - last_done), 10);
                last_done = cyc;
                if (k < 2) begin
                    a8 = ba[k+1]; b8 = bb[k+1]; cin8 = bc[k+1];
                end else begin
                    start8 = 1'b0;
                end
                repeat (5) @(negedge clk);
                chk("b2b_hold", {cout8, sum8}, be[k]);
            end
        end

        // WIDTH=1: all eight input combinations.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a1 = i[0]; b1 = i[1]; cin1 = i[2];
            start1 = 1'b1;
            q1.push_back(2'(i[0]) + 2'(i[1]) + 2'(i[2]));
            @(negedge clk);                     // after E0
            start1 = 1'b0;
            chk("w1_busy", {ready1, done1}, 2'b00);
            @(negedge clk);                     // after E1
            chk("w1_done", {ready1, done1}, 2'b01);
            @(negedge clk);                     // after E2
            chk("w1_idle", {ready1, done1}, 2'b10);
        end

        repeat (2) @(negedge clk);
        chk("q8_drained", 64'(q8.size()), 0);
        chk("q1_drained", 64'(q1.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder, LSB first: one full-adder cell plus a carry flip-flop, sequenced by a small FSM with a start/ready/done handshake. It performs the addition that the full subtractor's borrow chain undoes. It is the area-minimal adder of the arithmetic library, for datapaths that can spend WIDTH+1 cycles per operation. Downstream blocks use it as a drop-in alternative to a ripple-carry adder.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..64.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only on an edge where ready=1.
- a  input  WIDTH  addend A; sampled on the accepting edge only.
- b  input  WIDTH  addend B; sampled on the accepting edge only.
- carry_in  input  1  carry into bit 0; sampled on the accepting edge only.
- ready  output  1  high in IDLE.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result register.
- carry_out  output  1  carry out of bit WIDTH-1.

## Operation
- The FSM has three states: IDLE, SHIFT, DONE.
- IDLE:
  - ready=1.
  - On start=1: load A/B shift registers from a/b, carry FF from carry_in, bit counter to 0, then go to SHIFT.
- SHIFT, one bit per edge:
  - The full_adder takes A[0], B[0] and the carry FF.
  - Its sum bit shifts into the MSB of the work register (right shift). A and B shift right. The carry FF takes the adder's cout. The counter increments.
  - On the edge where the counter equals WIDTH-1: copy the completed work register (including this bit) into sum, copy cout into carry_out, then go to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
- start is ignored while ready=0. It is not queued.
- Result: {carry_out, sum} = a + b + carry_in, computed as modulo 2^(WIDTH+1) arithmetic, unsigned.
- sum and carry_out hold their value from the completing edge until the next operation completes. They do not change during SHIFT.
- Counter width is max(1, $clog2(WIDTH)).
- WIDTH=1: SHIFT lasts exactly one edge.
- Reset, at any time including mid-SHIFT:
  - state returns to IDLE, ready=1, done=0, sum=0, carry_out=0;
  - shift registers, carry FF and counter are cleared;
  - an aborted operation never produces done.

## Timing
- The accepting edge is E0. Shift edges are E1..E_WIDTH.
- done is high during the cycle after E_WIDTH and falls at E_WIDTH+1.
- ready falls after E0 and rises after E_WIDTH+1.
- Minimum spacing between accepted starts is WIDTH+2 edges. start held high continuously gives back-to-back operations at that rate.
- sum/carry_out update at E_WIDTH and are valid for the whole done cycle.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Structure
- Shared package serial_arith_pkg:
  - state typedef (enum IDLE/SHIFT/DONE);
  - a counter-width helper function;
  - the WIDTH bounds as constants.
  - The planned serial_subtractor reuses this package.
- One sub-module: full_adder (minuend-style 1-bit ports a, b, carry_in, sum, carry_out), built from two half_adder instances and an OR, mirroring full_subtractor.
- Top level: FSM, counter, three shift registers, carry FF and output registers.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, carry_in=0 -> sum=0x96, carry_out=0. done high exactly in the cycle after the 8th shift edge. ready low for edges E1..E9.
- a=0xFF, b=0x01, carry_in=0 -> sum=0x00, carry_out=1. Checks full carry ripple across all bits.
- a=0xFF, b=0xFF, carry_in=1 -> sum=0xFF, carry_out=1. Second start pulses during SHIFT are ignored and the result is unchanged.
- rst asserted asynchronously after 4 shift edges:
  - outputs go to ready=1, done=0, sum=0, carry_out=0 immediately;
  - no done follows;
  - the next operation a=0x01, b=0x02 gives sum=0x03.
- start held high for 3 operations -> done pulses 10 edges apart. sum holds each result until the next completing edge.
- WIDTH=1, all 8 combinations of a/b/carry_in -> {carry_out,sum} = a+b+carry_in. done in the 2nd cycle after acceptance.
